// File: rtl/preamble_pkg.sv
// Shared constants, state encoding and the 802.11 legacy STF/LTF sample tables (Q15, {I, Q}).
package preamble_pkg;

  localparam int unsigned SHORT_PERIOD = 16;
  localparam int unsigned SHORT_REPS   = 10;
  localparam int unsigned LONG_SYM_LEN = 64;
  localparam int unsigned LONG_CP_LEN  = 32;
  localparam int unsigned STF_LEN      = SHORT_PERIOD * SHORT_REPS;
  localparam int unsigned LTF_LEN      = LONG_CP_LEN + 2 * LONG_SYM_LEN;
  localparam int unsigned SAMPLE_W     = 32;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned BURST_W      = 16;
  localparam int unsigned STF_IDX_W    = $clog2(SHORT_PERIOD);
  localparam int unsigned ROM_IDX_W    = $clog2(LONG_SYM_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHORT   = 2'd1,
    S_LONG    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                last;
  } beat_t;

  // Table values are given in thousandths of full scale and converted to Q15.
  function automatic logic [15:0] q15(input int milli);
    return 16'((milli * 32768) / 1000);
  endfunction

  function automatic logic [31:0] iq(input int i_milli, input int q_milli);
    return {q15(i_milli), q15(q_milli)};
  endfunction

  localparam logic [SAMPLE_W-1:0] STF_ROM [SHORT_PERIOD] = '{
    iq(  46,   46), iq(-132,    2), iq( -13,  -79), iq( 143,  -13),
    iq(  92,    0), iq( 143,  -13), iq( -13,  -79), iq(-132,    2),
    iq(  46,   46), iq(   2, -132), iq( -79,  -13), iq( -13,  143),
    iq(   0,   92), iq( -13,  143), iq( -79,  -13), iq(   2, -132)
  };

  localparam logic [SAMPLE_W-1:0] LTF_ROM [LONG_SYM_LEN] = '{
    iq( 156,    0), iq(  -5, -120), iq(  40, -111), iq(  97,   83),
    iq(  21,   28), iq(  60,  -88), iq(-115,  -55), iq( -38, -106),
    iq(  98,  -26), iq(  53,    4), iq(   1, -115), iq(-137,  -47),
    iq(  24,  -59), iq(  59,  -15), iq( -22,  161), iq( 119,   -4),
    iq(  62,  -62), iq(  37,   98), iq( -57,   39), iq(-131,   65),
    iq(  82,   92), iq(  70,   14), iq( -60,   81), iq( -56,  -22),
    iq( -35, -151), iq(-122,  -17), iq(-127,  -21), iq(  75,  -74),
    iq(  -3,   54), iq( -92,  115), iq(  92,  106), iq(  12,   98),
    iq(-156,    0), iq(  12,  -98), iq(  92, -106), iq( -92, -115),
    iq(  -3,  -54), iq(  75,   74), iq(-127,   21), iq(-122,   17),
    iq( -35,  151), iq( -56,   22), iq( -60,  -81), iq(  70,  -14),
    iq(  82,  -92), iq(-131,  -65), iq( -57,  -39), iq(  37,  -98),
    iq(  62,   62), iq( 119,    4), iq( -22, -161), iq(  59,   15),
    iq(  24,   59), iq(-137,   47), iq(   1,  115), iq(  53,   -4),
    iq(  98,   26), iq( -38,  106), iq(-115,   55), iq(  60,   88),
    iq(  21,  -28), iq(  97,  -83), iq(  40,  111), iq(  -5,  120)
  };

endpackage

// File: rtl/preamble_rom.sv
// Combinational lookup of one preamble sample from either the STF or the LTF table.
module preamble_rom
  import preamble_pkg::*;
(
  input  logic                 ltf_sel,
  input  logic [ROM_IDX_W-1:0] idx,
  output logic [SAMPLE_W-1:0]  sample_c
);

  always_comb begin
    sample_c = '0;
    if (ltf_sel) sample_c = LTF_ROM[idx];
    else         sample_c = STF_ROM[idx[STF_IDX_W-1:0]];
  end

endmodule

// File: rtl/preamble_inserter.sv
// Prepends the 320-sample legacy STF+LTF preamble to each AXI-Stream IQ burst, then passes the payload.
module preamble_inserter
  import preamble_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] i_tdata,
  input  logic                i_tlast,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [SAMPLE_W-1:0] o_tdata,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic                busy,
  output logic [BURST_W-1:0]  burst_count
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  beat_t                out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q;
  logic                 adv_c;
  logic                 rom_ltf_c;
  logic [ROM_IDX_W-1:0] rom_idx_c;
  logic [SAMPLE_W-1:0]  rom_sample_c;

  assign adv_c     = !valid_q || o_tready;
  assign rom_ltf_c = (state_q == S_LONG);
  // LTF starts mid-symbol (cyclic prefix); the symbol length is a power of two so truncation wraps it.
  assign rom_idx_c = rom_ltf_c ? ROM_IDX_W'(cnt_q[ROM_IDX_W-1:0] + ROM_IDX_W'(LONG_CP_LEN))
                               : ROM_IDX_W'(cnt_q[STF_IDX_W-1:0]);

  preamble_rom u_rom (
    .ltf_sel  (rom_ltf_c),
    .idx      (rom_idx_c),
    .sample_c (rom_sample_c)
  );

  // Next-state and output-register load logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
    out_d    = out_q;
    valid_d  = valid_q;
    i_tready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (adv_c) valid_d = 1'b0;
        if (enable && i_tvalid) begin
          state_d = S_SHORT;
          cnt_d   = '0;
        end
      end
      S_SHORT: begin
        if (adv_c) begin
          valid_d = 1'b1;
          out_d   = '{data: rom_sample_c, last: 1'b0};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STF_LEN - 1)) begin
            state_d = S_LONG;
            cnt_d   = '0;
          end
        end
      end
      S_LONG: begin
        if (adv_c) begin
          valid_d = 1'b1;
          out_d   = '{data: rom_sample_c, last: 1'b0};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(LTF_LEN - 1)) begin
            state_d = S_PAYLOAD;
            cnt_d   = '0;
          end
        end
      end
      S_PAYLOAD: begin
        i_tready = adv_c;
        if (adv_c) begin
          valid_d = i_tvalid;
          if (i_tvalid) begin
            out_d = '{data: i_tdata, last: i_tlast};
            if (i_tlast) begin
              burst_d = burst_q + 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      burst_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign o_tdata     = out_q.data;
  assign o_tlast     = out_q.last;
  assign o_tvalid    = valid_q;
  assign busy        = busy_q;
  assign burst_count = burst_q;

endmodule
